// File: rtl/if_fetch_buffer_if.sv
// Fetch-buffer bus bundle: redirect input, memory request/response, and decode handoff.
interface if_fetch_buffer_if #(
    parameter int unsigned XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;

    // Fetch-buffer side
    modport master (
        input  redirect_valid,
        input  redirect_pc,
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_addr,
        input  mem_rsp_valid,
        input  mem_rsp_data,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc
    );

    // Environment side (core control, memory, decode)
    modport slave (
        output redirect_valid,
        output redirect_pc,
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_addr,
        output mem_rsp_valid,
        output mem_rsp_data,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc
    );
endinterface

// File: rtl/if_fetch_buffer.sv
// Instruction fetch buffer: issues sequential fetches with a credit limit of DEPTH
// (buffered + in-flight), queues in-order responses with their PCs, and drains stale
// responses after a redirect.
module if_fetch_buffer #(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]    INST_NOP = 32'h0000_0013
) (
    input logic               clk,
    input logic               rst,
    if_fetch_buffer_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]     DepthW = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] PcStep = XLEN'(4);

    localparam logic [0:0] StFetch = 1'b0;
    localparam logic [0:0] StDrain = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    logic [CW:0] inflight;
    logic        req_fire;
    logic        push;
    logic        pop;
    logic        head_valid;

    // Request/handshake decode; a redirect suppresses the request, push and pop.
    always_comb begin
        inflight   = {1'b0, count_q} + {1'b0, outst_q};
        head_valid = (count_q != '0);
        req_fire   = bus.mem_req_valid && bus.mem_req_ready;
        push       = (state_q == StFetch) && bus.mem_rsp_valid && !bus.redirect_valid;
        pop        = head_valid && bus.inst_ready && !bus.redirect_valid;
    end

    assign bus.mem_req_valid = (state_q == StFetch) && !bus.redirect_valid && (inflight < DepthW);
    assign bus.mem_req_addr  = fetch_pc_q;
    assign bus.inst_valid    = head_valid;
    assign bus.inst          = head_valid ? inst_mem[rptr_q] : INST_NOP;
    assign bus.inst_pc       = head_valid ? pc_mem[rptr_q] : rsp_pc_q;

    // Next-state: credit bookkeeping, FIFO pointers, PCs and drain FSM.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        // Every response returns a credit, including stale or discarded ones.
        outst_d    = outst_q + CW'(req_fire) - CW'(bus.mem_rsp_valid);

        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            rsp_pc_d   = bus.redirect_pc;
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            state_d    = (outst_d != '0) ? StDrain : StFetch;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PcStep;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + PcStep;
                wptr_d   = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            // Leave DRAIN on the cycle the last stale response arrives.
            if ((state_q == StDrain) && (outst_d == '0)) begin
                state_d = StFetch;
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFetch;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Buffer storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr_q]   <= rsp_pc_q;
            inst_mem[wptr_q] <= bus.mem_rsp_data;
        end
    end
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer: in-order memory model with 1-cycle latency.
module tb_if_fetch_buffer;
    logic clk = 1'b0;
    logic rst;

    if_fetch_buffer_if #(.XLEN(32)) bus ();

    if_fetch_buffer #(
        .XLEN(32),
        .DEPTH(4),
        .RESET_PC(32'h0000_0000),
        .INST_NOP(32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    logic [31:0] pend[$];
    logic        rsp_en = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_rsp();
        bus.mem_rsp_valid = rsp_en && (pend.size() > 0);
        bus.mem_rsp_data  = (pend.size() > 0) ? mem_word(pend[0]) : 32'h0;
    endtask

    // One clock: record handshakes, advance the memory model, settle.
    task automatic cycle();
        logic        acc;
        logic        fired;
        logic [31:0] a;
        #3;
        acc   = bus.mem_req_valid && bus.mem_req_ready;
        a     = bus.mem_req_addr;
        fired = bus.mem_rsp_valid;
        @(posedge clk);
        #1;
        if (fired) void'(pend.pop_front());
        if (acc) begin
            pend.push_back(a);
            acc_cnt++;
        end
        drive_rsp();
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.mem_rsp_valid  = 1'b0;
        pend.delete();
        acc_cnt = 0;
        #1;
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst_inst", bus.inst, 32'h0000_0013);
        chk("rst_req_addr", bus.mem_req_addr, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        bus.redirect_pc   = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.inst_ready    = 1'b0;

        // Streaming fetch after reset release
        reset_dut();
        bus.mem_req_ready = 1'b1;
        bus.inst_ready    = 1'b1;
        rsp_en            = 1'b1;
        #1;
        chk("boot_req_valid", 32'(bus.mem_req_valid), 32'h1);
        chk("boot_req_addr", bus.mem_req_addr, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            cycle();
            chk("stream_req_addr", bus.mem_req_addr, 32'(4 * i));
            if (i >= 2) begin
                chk("stream_inst_valid", 32'(bus.inst_valid), 32'h1);
                chk("stream_inst_pc", bus.inst_pc, 32'(4 * (i - 2)));
                chk("stream_inst", bus.inst, mem_word(32'(4 * (i - 2))));
            end else begin
                chk("stream_no_bypass", 32'(bus.inst_valid), 32'h0);
            end
        end

        // Mid-operation reset, then fill the buffer with decode stalled
        bus.inst_ready = 1'b0;
        reset_dut();
        for (int i = 0; i < 5; i++) cycle();
        chk("full_req_valid", 32'(bus.mem_req_valid), 32'h0);
        chk("full_accepts", 32'(acc_cnt), 32'd4);
        chk("full_head_pc", bus.inst_pc, 32'h0);
        bus.inst_ready = 1'b1;
        cycle();
        bus.inst_ready = 1'b0;
        #1;
        chk("pop1_head_pc", bus.inst_pc, 32'h4);
        chk("pop1_req_valid", 32'(bus.mem_req_valid), 32'h1);
        chk("pop1_req_addr", bus.mem_req_addr, 32'h10);
        cycle();
        chk("refull_req_valid", 32'(bus.mem_req_valid), 32'h0);
        chk("refull_accepts", 32'(acc_cnt), 32'd5);
        cycle();
        bus.inst_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_order_pc", bus.inst_pc, 32'(4 * (k + 1)));
            chk("drain_order_inst", bus.inst, mem_word(32'(4 * (k + 1))));
            cycle();
        end

        // Redirect with two responses outstanding
        reset_dut();
        bus.mem_req_ready = 1'b1;
        bus.inst_ready    = 1'b1;
        rsp_en            = 1'b0;
        cycle();
        cycle();
        bus.mem_req_ready  = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        chk("redir_req_withheld", 32'(bus.mem_req_valid), 32'h0);
        cycle();
        bus.redirect_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        rsp_en             = 1'b1;
        drive_rsp();
        #1;
        chk("drain_req_valid", 32'(bus.mem_req_valid), 32'h0);
        chk("drain_inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("drain_inst_nop", bus.inst, 32'h0000_0013);
        chk("drain_inst_pc", bus.inst_pc, 32'h100);
        cycle();
        chk("drain_last_req_valid", 32'(bus.mem_req_valid), 32'h0);
        chk("drain_stale_dropped", 32'(bus.inst_valid), 32'h0);
        cycle();
        chk("post_drain_req_valid", 32'(bus.mem_req_valid), 32'h1);
        chk("post_drain_req_addr", bus.mem_req_addr, 32'h100);
        chk("post_drain_empty", 32'(bus.inst_valid), 32'h0);
        cycle();
        chk("post_drain_empty2", 32'(bus.inst_valid), 32'h0);
        cycle();
        chk("redir_first_pc", bus.inst_pc, 32'h100);
        chk("redir_first_inst", bus.inst, mem_word(32'h100));

        // Redirect with nothing outstanding, target at the top of the address space
        reset_dut();
        rsp_en             = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        #1;
        chk("idle_redir_req_valid", 32'(bus.mem_req_valid), 32'h0);
        cycle();
        bus.redirect_valid = 1'b0;
        #1;
        chk("idle_redir_next_valid", 32'(bus.mem_req_valid), 32'h1);
        chk("idle_redir_next_addr", bus.mem_req_addr, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_req_addr", bus.mem_req_addr, 32'h0);
        cycle();
        chk("wrap_head_pc", bus.inst_pc, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_next_pc", bus.inst_pc, 32'h0);
        chk("wrap_next_inst", bus.inst, mem_word(32'h0));

        // Second redirect while draining
        reset_dut();
        rsp_en = 1'b0;
        cycle();
        cycle();
        bus.mem_req_ready  = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        #1;
        cycle();
        bus.redirect_pc = 32'h300;
        rsp_en          = 1'b1;
        drive_rsp();
        #1;
        chk("redir2_inst_valid", 32'(bus.inst_valid), 32'h0);
        cycle();
        bus.redirect_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        #1;
        chk("redir2_still_drain", 32'(bus.mem_req_valid), 32'h0);
        cycle();
        chk("redir2_req_valid", 32'(bus.mem_req_valid), 32'h1);
        chk("redir2_req_addr", bus.mem_req_addr, 32'h300);
        cycle();
        chk("redir2_empty", 32'(bus.inst_valid), 32'h0);
        cycle();
        chk("redir2_first_pc", bus.inst_pc, 32'h300);
        chk("redir2_first_inst", bus.inst, mem_word(32'h300));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_fetch_buffer.md
IF_FETCH_BUFFER -- requirements
Module: if_fetch_buffer

Interface
REQ-001 Parameter XLEN, default 32: address and PC width.
REQ-002 Parameter DEPTH, default 4: instruction buffer entries (power of two, >=2); this is also the maximum outstanding fetch count.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 Parameter INST_NOP, default 32'h0000_0013: value driven on inst when the buffer is empty.
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  reset; asserted high is in reset.
REQ-008 redirect_valid  in  1  branch/jump redirect request.
REQ-009 redirect_pc  in  XLEN  new fetch address, sampled when redirect_valid=1.
REQ-010 mem_req_valid  out  1  fetch request valid.
REQ-011 mem_req_ready  in  1  memory accepts the request.
REQ-012 mem_req_addr  out  XLEN  fetch address.
REQ-013 mem_rsp_valid  in  1  fetched word valid; responses return in request order, latency >=1 cycle.
REQ-014 mem_rsp_data  in  32  fetched instruction.
REQ-015 inst_valid  out  1  buffer head valid.
REQ-016 inst_ready  in  1  decode consumes the head.
REQ-017 inst  out  32  head instruction, or INST_NOP when empty.
REQ-018 inst_pc  out  XLEN  PC of the head instruction.

Function
REQ-019 Registers: fetch_pc, rsp_pc, outstanding (0..DEPTH), FIFO of {pc,inst} with count (0..DEPTH), 2-state FSM {FETCH, DRAIN}.
REQ-020 mem_req_valid = (state==FETCH) & !redirect_valid & (count+outstanding < DEPTH); mem_req_addr = fetch_pc.
REQ-021 A request is accepted when mem_req_valid & mem_req_ready: fetch_pc += 4 (wraps modulo 2^XLEN), outstanding += 1.
REQ-022 mem_req_valid is withdrawn without acceptance only in a redirect cycle; otherwise it is held with a stable address until accepted.
REQ-023 Every mem_rsp_valid decrements outstanding; simultaneous accept and response leave it unchanged.
REQ-024 In FETCH, a response pushes {rsp_pc, mem_rsp_data} and advances rsp_pc += 4; the credit rule guarantees the FIFO never overflows.
REQ-025 In DRAIN, responses are discarded, with no push and no rsp_pc update.
REQ-026 Redirect (any state): FIFO flushed (count=0, pointers reset), fetch_pc=rsp_pc=redirect_pc; any response in that cycle is discarded; inst_ready in that cycle has no effect.
REQ-027 Redirect next state: DRAIN if outstanding after this cycle's response is >0, else FETCH.
REQ-028 DRAIN->FETCH when outstanding reaches 0, i.e. the cycle of the last stale response; the first new request issues in the following cycle.
REQ-029 inst_valid = (count>0); pop on inst_valid & inst_ready. No bypass: a response at cycle N is visible at cycle N+1.
REQ-030 Simultaneous push and pop: count unchanged and ordering preserved; this includes the full case.
REQ-031 With inst_valid=0: inst = INST_NOP and inst_pc = rsp_pc.

Reset
REQ-032 While rst=1: state=FETCH, fetch_pc=rsp_pc=RESET_PC, outstanding=0, count=0, inst_valid=0, inst=INST_NOP, mem_req_addr=RESET_PC.
REQ-033 rst asserted mid-operation: buffered entries and in-flight bookkeeping are lost immediately. The environment is responsible for memory not returning pre-reset responses.
REQ-034 In the first cycle after rst deasserts, mem_req_valid=1 with addr=RESET_PC.

Verification
REQ-035 Reset release, ready=1, 1-cycle response latency, inst_ready=1 -> requests issued to 0x0,0x4,0x8,... one per cycle; inst_pc sequence 0x0,0x4,... with inst matching memory.
REQ-036 inst_ready=0, DEPTH=4 -> exactly 4 requests accepted, then mem_req_valid=0; count=4; raising inst_ready for one cycle pops 0x0 and one new request issues.
REQ-037 Redirect to 0x100 with 2 outstanding -> FSM=DRAIN, FIFO empty, inst=INST_NOP; both stale responses dropped; next request addr=0x100, first inst_pc=0x100.
REQ-038 Redirect with 0 outstanding -> stays FETCH, mem_req_valid=0 in the redirect cycle, request to redirect_pc in the next cycle.
REQ-039 fetch_pc=0xFFFF_FFFC, request accepted -> next addr 0x0000_0000.
REQ-040 Second redirect during DRAIN (0x200 then 0x300) -> all pre-redirect responses dropped; first inst_pc=0x300.
